// File: rtl/mini_i_cache_pkg.sv
// Shared definitions for the mini instruction cache.
// Holds the controller state encoding and the default parameter values
// used by mini_i_cache and mini_i_cache_mem.
package mini_i_cache_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefNumLines  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StBusReq,
    StBusWait,
    StRespond
  } state_e;

endpackage

// File: rtl/mini_i_cache_mem.sv
// Tag/data/valid storage for the direct-mapped instruction cache.
// Ports:
//   clock, reset       - clock and asynchronous active-high reset (clears valid bits only)
//   rd_idx             - line index for the registered read port
//   rd_valid/tag/data  - line contents, one cycle after rd_idx is presented
//   wr_en, wr_idx      - write strobe and line index
//   wr_tag, wr_data    - tag and word stored on write; the line is marked valid
module mini_i_cache_mem
  import mini_i_cache_pkg::*;
#(
  parameter int unsigned data_width = DefDataWidth,
  parameter int unsigned tag_width  = DefAddrWidth - 6,
  parameter int unsigned num_lines  = DefNumLines,
  localparam int unsigned idx_bits  = $clog2(num_lines)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [idx_bits-1:0]   rd_idx,
  output logic                  rd_valid,
  output logic [tag_width-1:0]  rd_tag,
  output logic [data_width-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [idx_bits-1:0]   wr_idx,
  input  logic [tag_width-1:0]  wr_tag,
  input  logic [data_width-1:0] wr_data
);

  logic [num_lines-1:0]  valid_q;
  logic [tag_width-1:0]  tag_q  [num_lines];
  logic [data_width-1:0] data_q [num_lines];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) valid_q[wr_idx] <= 1'b1;
      rd_valid <= valid_q[rd_idx];
    end
  end

  // Tag and data arrays are not reset; the valid bits alone gate hits.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
    rd_tag  <= tag_q[rd_idx];
    rd_data <= data_q[rd_idx];
  end

endmodule

// File: rtl/mini_i_cache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Ports:
//   clock, reset                               - clock, asynchronous active-high reset
//   ir_addr_valid/ir_addr/ir_addr_ready        - CPU fetch request channel
//   ir_data_valid/ir_data/ir_data_ready        - CPU fetch response channel
//   bus_ir_addr_valid/bus_ir_addr/_ready       - miss request to the memory bus
//   bus_ir_data_valid/bus_ir_data/_ready       - memory bus reply channel
// One fetch is outstanding at a time; all outputs are registered.
module mini_i_cache
  import mini_i_cache_pkg::*;
#(
  parameter int unsigned data_width = DefDataWidth,
  parameter int unsigned addr_width = DefAddrWidth,
  parameter int unsigned num_lines  = DefNumLines
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ir_addr_valid,
  input  logic [addr_width-1:0] ir_addr,
  output logic                  ir_addr_ready,
  output logic                  ir_data_valid,
  output logic [data_width-1:0] ir_data,
  input  logic                  ir_data_ready,
  output logic                  bus_ir_addr_valid,
  output logic [addr_width-1:0] bus_ir_addr,
  input  logic                  bus_ir_addr_ready,
  input  logic                  bus_ir_data_valid,
  input  logic [data_width-1:0] bus_ir_data,
  output logic                  bus_ir_data_ready
);

  localparam int unsigned idx_bits  = $clog2(num_lines);
  localparam int unsigned tag_width = addr_width - idx_bits - 2;

  state_e                state_q;
  logic [addr_width-1:0] addr_q;
  logic                  rd_wait_q;

  logic                  rd_valid;
  logic [tag_width-1:0]  rd_tag;
  logic [data_width-1:0] rd_data;
  logic                  hit;
  logic                  fill;

  assign hit  = rd_valid && (rd_tag == addr_q[addr_width-1:idx_bits+2]);
  assign fill = (state_q == StBusWait) && bus_ir_data_valid && bus_ir_data_ready;

  mini_i_cache_mem #(
    .data_width(data_width),
    .tag_width (tag_width),
    .num_lines (num_lines)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .rd_idx  (addr_q[idx_bits+1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill),
    .wr_idx  (addr_q[idx_bits+1:2]),
    .wr_tag  (addr_q[addr_width-1:idx_bits+2]),
    .wr_data (bus_ir_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= StIdle;
      addr_q            <= '0;
      rd_wait_q         <= 1'b0;
      ir_addr_ready     <= 1'b1;
      ir_data_valid     <= 1'b0;
      ir_data           <= '0;
      bus_ir_addr_valid <= 1'b0;
      bus_ir_addr       <= '0;
      bus_ir_data_ready <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ir_addr_valid && ir_addr_ready) begin
            addr_q        <= ir_addr;
            ir_addr_ready <= 1'b0;
            rd_wait_q     <= 1'b1;
            state_q       <= StLookup;
          end
        end
        StLookup: begin
          // The storage read port is registered: first cycle only lets it
          // sample the new index, the second cycle makes the hit decision.
          if (rd_wait_q) begin
            rd_wait_q <= 1'b0;
          end else if (hit) begin
            ir_data       <= rd_data;
            ir_data_valid <= 1'b1;
            state_q       <= StRespond;
          end else begin
            bus_ir_addr       <= addr_q;
            bus_ir_addr_valid <= 1'b1;
            state_q           <= StBusReq;
          end
        end
        StBusReq: begin
          if (bus_ir_addr_ready) begin
            bus_ir_addr_valid <= 1'b0;
            bus_ir_data_ready <= 1'b1;
            state_q           <= StBusWait;
          end
        end
        StBusWait: begin
          if (bus_ir_data_valid) begin
            bus_ir_data_ready <= 1'b0;
            ir_data           <= bus_ir_data;
            ir_data_valid     <= 1'b1;
            state_q           <= StRespond;
          end
        end
        StRespond: begin
          if (ir_data_ready) begin
            ir_data_valid <= 1'b0;
            ir_addr_ready <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_i_cache.sv
// Bench for mini_i_cache: a bus-functional interface driving the CPU and
// memory-bus channels, plus a reference model of a direct-mapped cache.
interface mini_i_cache_bfm #(
  parameter int unsigned data_width = 32,
  parameter int unsigned addr_width = 32
);
  localparam int Budget = 60;

  logic                  clock;
  logic                  rst;
  logic                  ir_addr_valid;
  logic [addr_width-1:0] ir_addr;
  logic                  ir_addr_ready;
  logic                  ir_data_valid;
  logic [data_width-1:0] ir_data;
  logic                  ir_data_ready;
  logic                  bus_ir_addr_valid;
  logic [addr_width-1:0] bus_ir_addr;
  logic                  bus_ir_addr_ready;
  logic                  bus_ir_data_valid;
  logic [data_width-1:0] bus_ir_data;
  logic                  bus_ir_data_ready;

  int addr_hold    = 0;
  int data_hold    = 0;
  int last_latency = 0;
  int bus_req_cnt  = 0;
  int resp_cnt     = 0;
  int stab_err     = 0;
  bit timed_out    = 0;

  logic                  p_bv = 0, p_br = 0, p_dv = 0, p_dr = 0;
  logic [addr_width-1:0] p_ba = '0;
  logic [data_width-1:0] p_d  = '0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Transfer counting and valid/payload stability, sampled mid-cycle.
  always @(negedge clock) begin
    if (rst !== 1'b0) begin
      p_bv <= 1'b0;
      p_dv <= 1'b0;
    end else begin
      if (bus_ir_addr_valid && bus_ir_addr_ready) bus_req_cnt <= bus_req_cnt + 1;
      if (ir_data_valid && ir_data_ready) resp_cnt <= resp_cnt + 1;
      if (p_bv && !p_br && (!bus_ir_addr_valid || bus_ir_addr !== p_ba)) stab_err <= stab_err + 1;
      if (p_dv && !p_dr && (!ir_data_valid || ir_data !== p_d)) stab_err <= stab_err + 1;
      p_bv <= bus_ir_addr_valid;
      p_br <= bus_ir_addr_ready;
      p_ba <= bus_ir_addr;
      p_dv <= ir_data_valid;
      p_dr <= ir_data_ready;
      p_d  <= ir_data;
    end
  end

  task automatic reset();
    rst               = 1'b1;
    ir_addr_valid     = 1'b0;
    ir_addr           = '0;
    ir_data_ready     = 1'b1;
    bus_ir_addr_ready = 1'b0;
    bus_ir_data_valid = 1'b0;
    bus_ir_data       = '0;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
  endtask

  task automatic read(input logic [addr_width-1:0] a, output logic [data_width-1:0] d);
    int n;
    d             = '0;
    last_latency  = -1;
    ir_addr_valid = 1'b1;
    ir_addr       = a;
    if (data_hold > 0) ir_data_ready = 1'b0;
    n = 0;
    @(negedge clock);
    while (!ir_addr_ready && n < Budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= Budget) begin
      timed_out = 1; ir_addr_valid = 1'b0; ir_data_ready = 1'b1;
      return;
    end
    @(posedge clock);
    #1 ir_addr_valid = 1'b0;
    // n ends as the number of rising edges after the request transfer edge.
    n = 0;
    @(negedge clock);
    while (!ir_data_valid && n < Budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= Budget) begin
      timed_out = 1; ir_data_ready = 1'b1;
      return;
    end
    last_latency = n;
    if (data_hold == 0) begin
      d = ir_data;
    end else begin
      repeat (data_hold - 1) @(negedge clock);
      @(posedge clock);
      #1 ir_data_ready = 1'b1;
      @(negedge clock);
      d = ir_data;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic bus_recv(output logic [addr_width-1:0] a);
    int n;
    a = '0;
    n = 0;
    @(negedge clock);
    while (!bus_ir_addr_valid && n < Budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= Budget) begin
      timed_out = 1;
      return;
    end
    repeat (addr_hold) @(negedge clock);
    @(posedge clock);
    #1 bus_ir_addr_ready = 1'b1;
    @(negedge clock);
    a = bus_ir_addr;
    @(posedge clock);
    #1 bus_ir_addr_ready = 1'b0;
  endtask

  task automatic bus_reply(input logic [data_width-1:0] d);
    int n;
    bus_ir_data_valid = 1'b1;
    bus_ir_data       = d;
    n = 0;
    @(negedge clock);
    while (!bus_ir_data_ready && n < Budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= Budget) begin
      timed_out = 1; bus_ir_data_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 bus_ir_data_valid = 1'b0;
  endtask
endinterface

module tb_mini_i_cache;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 16;

  mini_i_cache_bfm #(.data_width(DW), .addr_width(AW)) bfm ();

  mini_i_cache #(
    .data_width(DW),
    .addr_width(AW),
    .num_lines (NL)
  ) dut (
    .clock            (bfm.clock),
    .reset            (bfm.rst),
    .ir_addr_valid    (bfm.ir_addr_valid),
    .ir_addr          (bfm.ir_addr),
    .ir_addr_ready    (bfm.ir_addr_ready),
    .ir_data_valid    (bfm.ir_data_valid),
    .ir_data          (bfm.ir_data),
    .ir_data_ready    (bfm.ir_data_ready),
    .bus_ir_addr_valid(bfm.bus_ir_addr_valid),
    .bus_ir_addr      (bfm.bus_ir_addr),
    .bus_ir_addr_ready(bfm.bus_ir_addr_ready),
    .bus_ir_data_valid(bfm.bus_ir_data_valid),
    .bus_ir_data      (bfm.bus_ir_data),
    .bus_ir_data_ready(bfm.bus_ir_data_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which tag and word each line holds, if any.
  bit            mv   [NL];
  logic [AW-1:0] mtag [NL];
  logic [DW-1:0] mdat [NL];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] reply);
    int            idx;
    logic [AW-1:0] tg;
    bit            hit;
    int            b0, r0;
    logic [AW-1:0] ba;
    logic [DW-1:0] got, exp;
    idx = int'((a / 4) % NL);
    tg  = a / (4 * NL);
    hit = mv[idx] && (mtag[idx] == tg);
    exp = hit ? mdat[idx] : reply;
    bfm.timed_out = 0;
    b0 = bfm.bus_req_cnt;
    r0 = bfm.resp_cnt;
    ba = '0;
    fork
      bfm.read(a, got);
      begin
        if (!hit) begin
          bfm.bus_recv(ba);
          bfm.bus_reply(reply);
        end
      end
    join
    check_val("timeout", 64'(bfm.timed_out), 64'(0));
    check_val("fetch_data", 64'(got), 64'(exp));
    check_val("bus_request_count", 64'(bfm.bus_req_cnt - b0), 64'(hit ? 0 : 1));
    check_val("response_count", 64'(bfm.resp_cnt - r0), 64'(1));
    if (!hit) check_val("bus_addr", 64'(ba), 64'(a));
    else      check_val("hit_latency", 64'(bfm.last_latency), 64'(2));
    if (!hit) begin
      mv[idx]   = 1'b1;
      mtag[idx] = tg;
      mdat[idx] = reply;
    end
    if (bfm.timed_out) begin
      bfm.reset();
      model_clear();
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ba;
    logic [AW-1:0] a;
    int            late_acc;

    model_clear();
    bfm.reset();
    @(negedge bfm.clock);
    check_val("reset_addr_ready", 64'(bfm.ir_addr_ready), 64'(1));
    check_val("reset_data_valid", 64'(bfm.ir_data_valid), 64'(0));
    check_val("reset_bus_addr_valid", 64'(bfm.bus_ir_addr_valid), 64'(0));
    check_val("reset_bus_data_ready", 64'(bfm.bus_ir_data_ready), 64'(0));
    check_val("reset_ir_data", 64'(bfm.ir_data), 64'(0));
    check_val("reset_bus_addr", 64'(bfm.bus_ir_addr), 64'(0));
    @(posedge bfm.clock);
    #1;

    // Miss, repeat hit, conflicting tag on the same line, re-miss.
    fetch(123, 101);
    fetch(123, 101);
    fetch(187, 202);
    fetch(123, 101);

    // Reset drops all cached lines.
    bfm.reset();
    model_clear();
    fetch(123, 101);

    // Back-pressure on both the bus request and the CPU response.
    bfm.addr_hold = 3;
    bfm.data_hold = 2;
    fetch(251, 101);
    bfm.addr_hold = 0;
    bfm.data_hold = 0;

    // Reset while waiting on the bus; the late reply must not be taken.
    bfm.ir_addr_valid = 1'b1;
    bfm.ir_addr       = 315;
    @(negedge bfm.clock);
    check_val("midop_addr_ready", 64'(bfm.ir_addr_ready), 64'(1));
    @(posedge bfm.clock);
    #1 bfm.ir_addr_valid = 1'b0;
    bfm.timed_out = 0;
    bfm.bus_recv(ba);
    check_val("midop_bus_addr", 64'(ba), 64'(315));
    #2 bfm.rst = 1'b1;
    #1;
    check_val("midop_reset_bus_data_ready", 64'(bfm.bus_ir_data_ready), 64'(0));
    check_val("midop_reset_addr_valid", 64'(bfm.bus_ir_addr_valid), 64'(0));
    @(posedge bfm.clock);
    #1 bfm.rst = 1'b0;
    bfm.bus_ir_data_valid = 1'b1;
    bfm.bus_ir_data       = 77;
    late_acc = 0;
    repeat (3) begin
      @(negedge bfm.clock);
      if (bfm.bus_ir_data_ready) late_acc++;
    end
    @(posedge bfm.clock);
    #1 bfm.bus_ir_data_valid = 1'b0;
    check_val("late_reply_accepted", 64'(late_acc), 64'(0));
    model_clear();
    fetch(315, 55);

    // Random traffic over a few tags so hits, misses and evictions mix.
    for (int i = 0; i < 60; i++) begin
      a = AW'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      bfm.addr_hold = int'($urandom_range(0, 2));
      bfm.data_hold = int'($urandom_range(0, 2));
      fetch(a, DW'($urandom));
    end
    bfm.addr_hold = 0;
    bfm.data_hold = 0;

    check_val("valid_payload_stability", 64'(bfm.stab_err), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
